// File: rtl/serial_to_parallel_pkg.sv
// Shared constants and helpers for the serial-to-parallel frame collector.
package serial_to_parallel_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_BUFFER_SIZE = 16;

  // Width of a write index that addresses bs slots; never narrower than 1 bit.
  function automatic int idx_width(input int bs);
    return (bs > 1) ? $clog2(bs) : 1;
  endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Collects single WIDTH-bit words into a BUFFER_SIZE-word frame and presents
// the frame as one parallel beat with a valid/ready handshake. A last marker
// closes a frame early; unused slots are zero-filled and the real word count
// travels alongside the frame.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter  int WIDTH       = DEFAULT_WIDTH,
  parameter  int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
  localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WIDTH-1:0]                      data_in,
  input  logic                                  data_in_valid,
  input  logic                                  data_in_last,
  output logic                                  data_in_ready,
  output logic [BUFFER_SIZE-1:0][WIDTH-1:0]     data_out,
  output logic [CNT_W-1:0]                      data_out_count,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready
);

  localparam int IDX_W  = idx_width(BUFFER_SIZE);
  localparam bit SINGLE = (BUFFER_SIZE == 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [BUFFER_SIZE-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             accept;

  // Ready is unconditional while filling; while holding it passes the
  // consumer's ready straight through so a new frame can start with no bubble.
  always_comb begin
    data_in_ready = 1'b1;
    if (state_q == HOLD) begin
      data_in_ready = data_out_ready;
    end
  end

  assign accept         = data_in_valid && data_in_ready;
  assign data_out       = data_q;
  assign data_out_count = count_q;
  assign data_out_valid = (state_q == HOLD);

  // Next-state logic: slot writes, zero-fill of the frame tail, count capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          data_d[idx_q] = data_in;
          if ((idx_q == IDX_W'(BUFFER_SIZE - 1)) || data_in_last) begin
            // Slots beyond the closing word carry stale data; clear them.
            for (int i = 0; i < BUFFER_SIZE; i++) begin
              if (i > int'(idx_q)) begin
                data_d[i] = '0;
              end
            end
            count_d = CNT_W'(idx_q) + CNT_W'(1);
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (data_out_ready) begin
          if (accept) begin
            // Handshake and first word of the next frame in the same cycle.
            data_d[0] = data_in;
            if (data_in_last || SINGLE) begin
              for (int i = 1; i < BUFFER_SIZE; i++) begin
                data_d[i] = '0;
              end
              count_d = CNT_W'(1);
              idx_d   = '0;
            end else begin
              idx_d   = IDX_W'(1);
              state_d = FILL;
            end
          end else begin
            idx_d   = '0;
            state_d = FILL;
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  // State, index, frame storage and count registers with async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized and directed bench for serial_to_parallel, checked against a
// frame-level reference model (word lists turned into expected frames).
module tb_serial_to_parallel;

  localparam int W  = 8;
  localparam int BS = 16;

  logic clk;
  logic rst;

  // Main instance (BUFFER_SIZE = 16)
  logic [W-1:0]          din;
  logic                  din_valid;
  logic                  din_last;
  logic                  din_ready;
  logic [BS-1:0][W-1:0]  dout;
  logic [4:0]            dout_count;
  logic                  dout_valid;
  logic                  dout_ready;

  // Degenerate instance (BUFFER_SIZE = 1)
  logic [W-1:0]          d1_in;
  logic                  d1_valid;
  logic                  d1_last;
  logic                  d1_ready;
  logic [0:0][W-1:0]     d1_out;
  logic [0:0]            d1_count;
  logic                  d1_out_valid;
  logic                  d1_out_ready;

  serial_to_parallel #(.WIDTH(W), .BUFFER_SIZE(BS)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .data_in_valid  (din_valid),
    .data_in_last   (din_last),
    .data_in_ready  (din_ready),
    .data_out       (dout),
    .data_out_count (dout_count),
    .data_out_valid (dout_valid),
    .data_out_ready (dout_ready)
  );

  serial_to_parallel #(.WIDTH(W), .BUFFER_SIZE(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .data_in        (d1_in),
    .data_in_valid  (d1_valid),
    .data_in_last   (d1_last),
    .data_in_ready  (d1_ready),
    .data_out       (d1_out),
    .data_out_count (d1_count),
    .data_out_valid (d1_out_valid),
    .data_out_ready (d1_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: words of the frame being collected, and closed frames
  // waiting for the consumer.
  typedef struct {
    logic [127:0] data;
    int           cnt;
  } frame_t;

  logic [7:0] cur_words[$];
  frame_t     frames[$];

  task automatic close_frame();
    frame_t f;
    f.data = '0;
    for (int i = 0; i < cur_words.size(); i++) begin
      f.data[i*8 +: 8] = cur_words[i];
    end
    f.cnt = cur_words.size();
    frames.push_back(f);
    cur_words.delete();
  endtask

  task automatic model_reset();
    cur_words.delete();
    frames.delete();
  endtask

  // One clock cycle on the main instance: drive inputs, check outputs, then
  // advance the model by what the upcoming edge will do.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r);
    bit exp_valid;
    @(negedge clk);
    din        = d;
    din_valid  = v;
    din_last   = l;
    dout_ready = r;
    #1;
    exp_valid = (frames.size() > 0);
    check_val("out_valid", {127'b0, dout_valid}, {127'b0, exp_valid});
    check_val("in_ready", {127'b0, din_ready}, {127'b0, (!exp_valid || r)});
    if (exp_valid) begin
      check_val("data_out", dout, frames[0].data);
      check_val("count", {123'b0, dout_count}, 128'(frames[0].cnt));
    end
    if (exp_valid && r) void'(frames.pop_front());
    if (v && (!exp_valid || r)) begin
      cur_words.push_back(d);
      if (l || cur_words.size() == BS) close_frame();
    end
  endtask

  initial begin
    logic [7:0] prev1;

    rst = 1'b0;
    din = '0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
    d1_in = '0; d1_valid = 1'b0; d1_last = 1'b0; d1_out_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_data", dout, '0);
    check_val("rst_count", {123'b0, dout_count}, '0);
    check_val("rst_valid", {127'b0, dout_valid}, '0);
    check_val("rst_ready", {127'b0, din_ready}, 128'd1);
    check_val("rst1_valid", {127'b0, d1_out_valid}, '0);
    @(negedge clk);
    rst = 1'b1;

    // Full frame: words 1..16, then drain
    for (int i = 0; i < BS; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Short frame closed by last on the third word
    step(1'b1, 8'hA0, 1'b0, 1'b1);
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Backpressure: frame held for 10 cycles while a word is offered,
    // then released with a same-cycle word that starts the next frame
    for (int i = 0; i < BS; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h56, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Streaming: 48 words back-to-back
    for (int i = 0; i < 48; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("midrst_data", dout, '0);
    check_val("midrst_count", {123'b0, dout_count}, '0);
    check_val("midrst_valid", {127'b0, dout_valid}, '0);
    check_val("midrst_ready", {127'b0, din_ready}, 128'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < BS; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 3) != 0));
    end
    // Drain
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Degenerate BUFFER_SIZE = 1: every word is a frame, one per cycle
    prev1 = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d1_in        = 8'(8'h90 + k);
      d1_valid     = (k < 4);
      d1_last      = 1'b0;
      d1_out_ready = 1'b1;
      #1;
      check_val("bs1_ready", {127'b0, d1_ready}, 128'd1);
      check_val("bs1_valid", {127'b0, d1_out_valid}, {127'b0, (k > 0)});
      if (k > 0) begin
        check_val("bs1_data", {120'b0, d1_out}, {120'b0, prev1});
        check_val("bs1_count", {127'b0, d1_count}, 128'd1);
      end
      prev1 = d1_in;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Collects a stream of single WIDTH-bit words into a BUFFER_SIZE-word array and presents the array as one parallel beat. It is the receive end of an array transfer: a word-at-a-time producer feeds it, and an array-wide consumer with a valid/ready interface drains it. A `data_in_last` marker closes a short frame early; unused slots are zero-filled, and the real word count travels with the frame.

## Interface
- `WIDTH`, 8, bits per word
- `BUFFER_SIZE`, 16, words per output array; legal range ≥ 1
- `CNT_W`, `$clog2(BUFFER_SIZE+1)` (derived, not overridable), width of the count output

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `data_in`  in  WIDTH  serial word
- `data_in_valid`  in  1  producer has a word
- `data_in_last`  in  1  qualifies `data_in`; this word closes the frame
- `data_in_ready`  out  1  block accepts `data_in` this cycle
- `data_out`  out  WIDTH × [BUFFER_SIZE-1:0]  assembled array; slot 0 holds the first word of the frame
- `data_out_count`  out  CNT_W  number of valid slots in the frame, 1..BUFFER_SIZE
- `data_out_valid`  out  1  array is complete and stable
- `data_out_ready`  in  1  consumer takes the array

## Operation
- Two states:
  - FILL: collecting words.
  - HOLD: presenting a frame.
- Registered write index `idx` (0..BUFFER_SIZE-1).
- An input word is accepted when `data_in_valid && data_in_ready`. The accepted word is written to slot `idx`.
- FILL:
  - `data_in_ready` = 1, `data_out_valid` = 0.
  - On accept with `idx == BUFFER_SIZE-1`, or with `data_in_last` = 1:
    - Slots `idx+1..BUFFER_SIZE-1` are cleared to 0.
    - `data_out_count` ← `idx+1`.
    - `idx` ← 0, go to HOLD.
  - Any other accept: `idx` ← `idx+1`.
- HOLD:
  - `data_out_valid` = 1.
  - `data_out` and `data_out_count` stay frozen until `data_out_ready` = 1.
  - `data_in_ready` = `data_out_ready`, giving a combinational pass-through for full throughput.
- HOLD exit on `data_out_ready` = 1:
  - Without a simultaneous accept: go to FILL. The array contents are don't-care until overwritten.
  - With a simultaneous accept: the new word goes to slot 0 of the next frame, and `idx` ← 1.
  - If that word also has `data_in_last` = 1, or `BUFFER_SIZE` = 1: stay in HOLD with a new frame of count 1, zero-filled.
- `data_in_last` is ignored when `data_in_valid` = 0.
- `data_out_valid` must never drop without a completed handshake.
- Reset, at any time including mid-frame:
  - State ← FILL, `idx` ← 0.
  - All array slots ← 0, `data_out_count` ← 0.
  - `data_out_valid` = 0, `data_in_ready` = 1.
  - A partially collected frame is discarded.

## Timing
- Frame latency: `data_out_valid` rises on the cycle after the edge that accepted the closing word.
- Throughput: one word per cycle sustained. The closing word's cycle is followed by a HOLD cycle. If `data_out_ready` = 1 in that cycle, the next frame's first word is accepted in it, so there are no bubbles.
- `data_in_ready` depends combinationally on `data_out_ready` in HOLD only. No other combinational input-to-output paths exist.
- All outputs except `data_in_ready` come directly from registers.
- Backpressure: the frame is held indefinitely while `data_out_ready` = 0. `data_in_ready` = 0 throughout.

## Structure
- No shared-package additions. The FILL/HOLD state enum is local to the module.
- Single module, no sub-modules. The index counter and zero-fill mask are inline.
- Target 150–250 lines.

## Test plan
- **Full frame.** Reset, `data_out_ready` = 1, feed words 1..16 back-to-back.
  - Expected: `data_out_valid` one cycle after word 16; `data_out[i]` = i+1; count = 16.
- **Short frame.** Feed 0xA0, 0xA1, 0xA2 with `data_in_last` on 0xA2.
  - Expected: slots 0..2 = A0..A2; slots 3..15 = 0; count = 3.
- **Backpressure.** Hold `data_out_ready` = 0 for 10 cycles after a frame completes.
  - Expected: `data_out` and count stable; `data_in_ready` = 0.
  - Release: handshake occurs, and a word offered in the same cycle lands in slot 0 of the next frame.
- **Streaming.** Feed 48 words with continuous valid and ready.
  - Expected: 3 frames, zero idle input cycles, correct contents per frame.
- **Reset mid-frame.** Assert `rst` = 0 after 5 words, then release and feed 16 new words.
  - Expected: outputs reset to 0 and valid = 0 during reset; the first output frame contains only the new words.
- **Degenerate configuration.** Build with `BUFFER_SIZE` = 1 and feed 4 consecutive words with ready held at 1.
  - Expected: 4 frames, count = 1 each, one word per cycle.
